// File: rtl/dualmux_sched.sv
// dualmux_sched: round-robin two-requester path scheduler with break-before-make guard
module dualmux_sched #(
  parameter int DWELL = 4,
  parameter int GUARD = 2,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic msel,
  output logic gnt0,
  output logic gnt1,
  output logic busy
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD} state_t;
  localparam logic [CNT_W-1:0] DW = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] GD = CNT_W'(GUARD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, msel_q, msel_d, gnt0_q, gnt0_d, gnt1_q, gnt1_d, busy_q, busy_d;
  logic win, own, oth;
  // Next state: one shared counter tracks dwell in GRANT and dead cycles in GUARD
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    msel_d = msel_q;
    gnt0_d = gnt0_q;
    gnt1_d = gnt1_q;
    win = (req0 & req1) ? ~last_q : req1;
    own = msel_q ? req1 : req0;
    oth = msel_q ? req0 : req1;
    if (state_q == S_GRANT) begin
      if (!own || (cnt_q == DW && oth)) begin
        state_d = S_GUARD;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        cnt_d = ONE;
      end else if (cnt_q != DW) begin
        cnt_d = cnt_q + ONE;
      end
    end else if (state_q == S_GUARD && cnt_q != GD) begin
      cnt_d = cnt_q + ONE;
    end else if (req0 | req1) begin
      state_d = S_GRANT;
      gnt0_d = ~win;
      gnt1_d = win;
      msel_d = win;
      last_d = win;
      cnt_d = ONE;
    end else begin
      state_d = S_IDLE;
      cnt_d = '0;
    end
    busy_d = state_d != S_IDLE;
  end
  // State and registered outputs; reset puts the pointer on 1 so req0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      msel_q <= 1'b0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      msel_q <= msel_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      busy_q <= busy_d;
    end
  end
  assign msel = msel_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_dualmux_sched.sv
// tb_dualmux_sched: directed test-plan sequences plus random traffic against a cycle-count model
module tb_dualmux_sched;
  localparam int DWELL = 4;
  localparam int GUARD = 2;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic msel, gnt0, gnt1, busy;
  int checks = 0, errors = 0;
  int owner = -1, held = 0, dead = 0, sel = 0, lastg = 1;
  logic mon = 1'b0, rn_s = 1'b0, msel_prev = 1'b0;
  dualmux_sched #(.DWELL(DWELL), .GUARD(GUARD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .msel(msel), .gnt0(gnt0), .gnt1(gnt1), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // Model: owner index, cycles held, dead cycles since release
  task automatic model(input logic r0, input logic r1, input logic rn);
    logic [1:0] r;
    int w;
    r = {r1, r0};
    if (!rn) begin
      owner = -1; held = 0; dead = 0; sel = 0; lastg = 1;
    end else if (owner >= 0) begin
      if (!r[owner] || (held >= DWELL && r[1-owner])) begin
        owner = -1; dead = 1;
      end else held++;
    end else if (dead > 0 && dead < GUARD) begin
      dead++;
    end else begin
      dead = 0;
      w = (r0 && r1) ? 1 - lastg : r0 ? 0 : r1 ? 1 : -1;
      if (w >= 0) begin
        owner = w; sel = w; lastg = w; held = 1;
      end
    end
  endtask
  task automatic step(input logic r0, input logic r1, input logic rn);
    req0 = r0; req1 = r1; rst_n = rn;
    @(posedge clk);
    model(r0, r1, rn);
    #1;
    chk("gnt0", gnt0, owner == 0);
    chk("gnt1", gnt1, owner == 1);
    chk("msel", msel, sel[0]);
    chk("busy", busy, owner >= 0 || dead > 0);
  endtask
  always @(posedge clk) rn_s = rst_n;
  // Continuous invariants: exclusive grants, msel moves only into a grant
  always @(negedge clk) if (mon) begin
    chk("excl", gnt0 & gnt1, 0);
    chk("msel_chg", (msel != msel_prev) && rn_s && !(gnt0 | gnt1), 0);
    msel_prev = msel;
  end
  initial begin
    logic a, b;
    #1;
    step(0, 0, 0);
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
    chk("rst_msel", msel, 0); chk("rst_busy", busy, 0);
    msel_prev = msel; mon = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1);
      chk("single_g0", gnt0, 1); chk("single_msel", msel, 0);
    end
    step(0, 0, 1); chk("single_rel", gnt0, 0); chk("single_busy1", busy, 1);
    step(0, 0, 1); chk("single_busy2", busy, 1);
    step(0, 0, 1); chk("single_idle", busy, 0);
    step(0, 0, 0);
    for (int c = 1; c <= 13; c++) begin
      step(1, 1, 1);
      chk("tie_g0", gnt0, (c <= 4) || (c == 13));
      chk("tie_g1", gnt1, (c >= 7) && (c <= 10));
    end
    step(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1);
      chk("lone_g1", gnt1, 1); chk("lone_busy", busy, 1);
    end
    step(1, 1, 1); chk("lone_pre", gnt1, 0);
    step(1, 1, 1); chk("lone_gap", gnt0, 0);
    step(1, 1, 1); chk("lone_g0", gnt0, 1); chk("lone_msel", msel, 0);
    step(0, 0, 0);
    step(1, 0, 1); step(1, 1, 1);
    step(0, 1, 1); chk("early_rel", gnt0, 0);
    step(0, 1, 1); chk("early_gap", gnt1, 0);
    step(0, 1, 1); chk("early_g1", gnt1, 1);
    step(0, 0, 0);
    step(0, 1, 1); step(0, 1, 1);
    step(1, 1, 0);
    chk("mid_gnt0", gnt0, 0); chk("mid_gnt1", gnt1, 0);
    chk("mid_msel", msel, 0); chk("mid_busy", busy, 0);
    step(1, 1, 1); chk("mid_first", gnt0, 1);
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) a = ~a;
      step(a, b, $urandom_range(0, 99) != 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
